idu_dispatch_queue: RTL and testbench

//  Parametrised successor to the dual-issue IDU, sitting between fetch/decode and the reservation stations.

---
 rtl/idu_dispatch_queue.sv | 177 +++++++++++++++++
 tb/tb_idu_dispatch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/idu_dispatch_queue.sv
// In-order dispatch queue feeding the adder/multiplier reservation stations, gated by per-class credits.
// Define IDU_DQ_BYPASS_EN to let incoming lanes dispatch in the same cycle when the queue drains.
`ifndef ADD
`define ADD 8'h01
`endif
`ifndef SUB
`define SUB 8'h02
`endif
`ifndef MUL
`define MUL 8'h03
`endif
`ifndef DIV
`define DIV 8'h04
`endif

module idu_dispatch_queue #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int TYPE_W  = 8,
  parameter int REG_W   = 8,
  parameter int CRED_W  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [ISSUE_W-1:0]                   in_valid,
  input  logic [ISSUE_W*(TYPE_W+3*REG_W)-1:0]  in_inst,
  output logic                                 in_ready,
  input  logic [CRED_W-1:0]                    add_rs_free,
  input  logic [CRED_W-1:0]                    mul_rs_free,
  output logic [ISSUE_W-1:0]                   out_valid,
  output logic [ISSUE_W*(TYPE_W+3*REG_W)-1:0]  out_inst,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy,
  output logic                                 illegal_op
);

  localparam int INST_W = TYPE_W + 3*REG_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);

  localparam logic [TYPE_W-1:0] OP_ADD = TYPE_W'(`ADD);
  localparam logic [TYPE_W-1:0] OP_SUB = TYPE_W'(`SUB);
  localparam logic [TYPE_W-1:0] OP_MUL = TYPE_W'(`MUL);
  localparam logic [TYPE_W-1:0] OP_DIV = TYPE_W'(`DIV);

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_BAD} op_class_e;

  function automatic op_class_e classify(input logic [TYPE_W-1:0] op);
    if (op == OP_ADD || op == OP_SUB)      return CLS_ADD;
    else if (op == OP_MUL || op == OP_DIV) return CLS_MUL;
    else                                   return CLS_BAD;
  endfunction

  logic [INST_W-1:0]         mem [DEPTH];
  logic [PTR_W-1:0]          head, tail;
  logic                      accept;
  int                        n_in, q_rm, byp_n, n_disp, n_enq;
  logic [ISSUE_W-1:0]        nxt_valid;
  logic [ISSUE_W*INST_W-1:0] nxt_inst;
  logic                      nxt_illegal;
  logic [CNT_W-1:0]          count_nxt;
  logic [CRED_W-1:0]         add_cr, mul_cr;
  logic                      stop, cand_v, cand_q, take, drop;
  logic [INST_W-1:0]         cand;
  op_class_e                 cls;

  assign accept = in_ready && !flush;

  always_comb begin
    n_in = 0;
    for (int j = 0; j < ISSUE_W; j++)
      if (in_valid[j]) n_in = n_in + 1;
  end

  // Scan slot i sees queued entry head+i, or (with bypass) the incoming lane behind the last queued entry.
  always_comb begin
    add_cr      = add_rs_free;
    mul_cr      = mul_rs_free;
    stop        = 1'b0;
    q_rm        = 0;
    byp_n       = 0;
    n_disp      = 0;
    nxt_valid   = '0;
    nxt_inst    = '0;
    nxt_illegal = 1'b0;
    cand_v      = 1'b0;
    cand_q      = 1'b0;
    cand        = '0;
    take        = 1'b0;
    drop        = 1'b0;
    cls         = CLS_BAD;
    for (int i = 0; i < ISSUE_W; i++) begin
      cand_v = 1'b0;
      cand_q = 1'b0;
      cand   = '0;
      take   = 1'b0;
      drop   = 1'b0;
      if (i < int'(occupancy)) begin
        cand_v = 1'b1;
        cand_q = 1'b1;
        cand   = mem[head + PTR_W'(i)];
      end
`ifdef IDU_DQ_BYPASS_EN
      else if (accept && in_valid[i - int'(occupancy)]) begin
        cand_v = 1'b1;
        cand   = in_inst[(i - int'(occupancy))*INST_W +: INST_W];
      end
`endif
      if (cand_v && !stop) begin
        cls = classify(cand[INST_W-1 -: TYPE_W]);
        case (cls)
          CLS_ADD: if (add_cr != '0) begin
            add_cr = add_cr - CRED_W'(1);
            take   = 1'b1;
          end
          CLS_MUL: if (mul_cr != '0) begin
            mul_cr = mul_cr - CRED_W'(1);
            take   = 1'b1;
          end
          default: drop = 1'b1;
        endcase
        if (take || drop) begin
          if (cand_q) q_rm = q_rm + 1;
          else        byp_n = byp_n + 1;
        end else begin
          stop = 1'b1;
        end
        if (drop) nxt_illegal = 1'b1;
        if (take) begin
          nxt_valid[n_disp]                  = 1'b1;
          nxt_inst[n_disp*INST_W +: INST_W]  = cand;
          n_disp                             = n_disp + 1;
        end
      end
    end
    n_enq     = accept ? (n_in - byp_n) : 0;
    count_nxt = occupancy + CNT_W'(n_enq) - CNT_W'(q_rm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= '0;
      out_inst   <= '0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= '0;
      out_inst   <= '0;
      illegal_op <= 1'b0;
    end else begin
      head       <= head + PTR_W'(q_rm);
      tail       <= tail + PTR_W'(n_enq);
      occupancy  <= count_nxt;
      in_ready   <= (DEPTH - int'(count_nxt)) >= ISSUE_W;
      out_valid  <= nxt_valid;
      out_inst   <= nxt_inst;
      illegal_op <= nxt_illegal;
    end
  end

  // Lanes already consumed by the bypass are skipped; the rest pack contiguously at tail.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int j = 0; j < ISSUE_W; j++)
        if (in_valid[j] && j >= byp_n)
          mem[tail + PTR_W'(j - byp_n)] <= in_inst[j*INST_W +: INST_W];
    end
  end

endmodule

// File: tb/tb_idu_dispatch_queue.sv
// Directed bench for idu_dispatch_queue: reset, ordering, credit stalls, full/wrap, illegal opcodes, flush.
`ifndef ADD
`define ADD 8'h01
`endif
`ifndef SUB
`define SUB 8'h02
`endif
`ifndef MUL
`define MUL 8'h03
`endif
`ifndef DIV
`define DIV 8'h04
`endif

module tb_idu_dispatch_queue;

  localparam logic [7:0] OP_ADD = `ADD;
  localparam logic [7:0] OP_MUL = `MUL;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_inst;
  logic        in_ready;
  logic [2:0]  add_rs_free;
  logic [2:0]  mul_rs_free;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [3:0]  occupancy;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  idu_dispatch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_inst     (in_inst),
    .in_ready    (in_ready),
    .add_rs_free (add_rs_free),
    .mul_rs_free (mul_rs_free),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .occupancy   (occupancy),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                     input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] l0, input logic [31:0] l1,
                               input logic [2:0] acr, input logic [2:0] mcr, input logic fl);
    in_valid    = v;
    in_inst     = {l1, l0};
    add_rs_free = acr;
    mul_rs_free = mcr;
    flush       = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_illegal", 64'(illegal_op), 64'd0);
    rst = 1'b0;

    $display("[TB] pair dispatch in order");
    applyStimulus(2'b11, mk(OP_MUL, 8'd2, 8'd0, 8'd1), mk(OP_ADD, 8'd5, 8'd3, 8'd4), 3'd1, 3'd1, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd1, 3'd1, 1'b0);
`ifdef IDU_DQ_BYPASS_EN
    checkOutput("t2_valid", 64'(out_valid), 64'd3);
    checkOutput("t2_inst", out_inst, {mk(OP_ADD, 8'd5, 8'd3, 8'd4), mk(OP_MUL, 8'd2, 8'd0, 8'd1)});
    checkOutput("t2_occ", 64'(occupancy), 64'd0);
`else
    checkOutput("t2_valid_early", 64'(out_valid), 64'd0);
    checkOutput("t2_occ_queued", 64'(occupancy), 64'd2);
    tick();
    checkOutput("t2_valid", 64'(out_valid), 64'd3);
    checkOutput("t2_inst", out_inst, {mk(OP_ADD, 8'd5, 8'd3, 8'd4), mk(OP_MUL, 8'd2, 8'd0, 8'd1)});
    checkOutput("t2_occ", 64'(occupancy), 64'd0);
`endif

    $display("[TB] ADD held behind stalled MUL");
    applyStimulus(2'b11, mk(OP_MUL, 8'd2, 8'd0, 8'd1), mk(OP_ADD, 8'd5, 8'd3, 8'd4), 3'd4, 3'd0, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd4, 3'd0, 1'b0);
    tick();
    checkOutput("t3_hold_valid", 64'(out_valid), 64'd0);
    checkOutput("t3_hold_occ", 64'(occupancy), 64'd2);
    tick();
    checkOutput("t3_hold_valid2", 64'(out_valid), 64'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd4, 3'd1, 1'b0);
    tick();
    checkOutput("t3_rel_valid", 64'(out_valid), 64'd3);
    checkOutput("t3_rel_inst", out_inst, {mk(OP_ADD, 8'd5, 8'd3, 8'd4), mk(OP_MUL, 8'd2, 8'd0, 8'd1)});
    checkOutput("t3_rel_occ", 64'(occupancy), 64'd0);

    $display("[TB] fill, full, drain with wrap");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, mk(OP_ADD, 8'(2*k), 8'd0, 8'd0), mk(OP_ADD, 8'(2*k+1), 8'd0, 8'd0),
                    3'd0, 3'd0, 1'b0);
      tick();
    end
    checkOutput("t4_full_occ", 64'(occupancy), 64'd8);
    checkOutput("t4_full_ready", 64'(in_ready), 64'd0);
    checkOutput("t4_full_valid", 64'(out_valid), 64'd0);
    applyStimulus(2'b11, mk(OP_ADD, 8'd100, 8'd0, 8'd0), mk(OP_ADD, 8'd101, 8'd0, 8'd0), 3'd0, 3'd0, 1'b0);
    tick();
    checkOutput("t4_ignored_occ", 64'(occupancy), 64'd8);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t4_ready", 64'(in_ready), (k == 0) ? 64'd0 : 64'd1);
      if (k >= 1 && k <= 6)
        applyStimulus(2'b11, mk(OP_ADD, 8'(8 + 2*(k-1)), 8'd0, 8'd0),
                      mk(OP_ADD, 8'(9 + 2*(k-1)), 8'd0, 8'd0), 3'd2, 3'd0, 1'b0);
      else
        applyStimulus(2'b00, 32'h0, 32'h0, 3'd2, 3'd0, 1'b0);
      tick();
      checkOutput("t4_drain_valid", 64'(out_valid), 64'd3);
      checkOutput("t4_drain_inst", out_inst,
                  {mk(OP_ADD, 8'(2*k+1), 8'd0, 8'd0), mk(OP_ADD, 8'(2*k), 8'd0, 8'd0)});
    end
    checkOutput("t4_empty_occ", 64'(occupancy), 64'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b0);
    tick();
    checkOutput("t4_empty_valid", 64'(out_valid), 64'd0);

    $display("[TB] unknown opcode dropped");
    applyStimulus(2'b11, mk(8'hFF, 8'd1, 8'd2, 8'd3), mk(OP_ADD, 8'd8, 8'd6, 8'd7), 3'd1, 3'd0, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd1, 3'd0, 1'b0);
`ifndef IDU_DQ_BYPASS_EN
    checkOutput("t5_illegal_early", 64'(illegal_op), 64'd0);
    checkOutput("t5_valid_early", 64'(out_valid), 64'd0);
    tick();
`endif
    checkOutput("t5_illegal", 64'(illegal_op), 64'd1);
    checkOutput("t5_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_inst", out_inst, {32'h0, mk(OP_ADD, 8'd8, 8'd6, 8'd7)});
    checkOutput("t5_occ", 64'(occupancy), 64'd0);
    tick();
    checkOutput("t5_illegal_pulse", 64'(illegal_op), 64'd0);
    checkOutput("t5_valid_after", 64'(out_valid), 64'd0);

    $display("[TB] flush with pending entries and inputs");
    applyStimulus(2'b11, mk(OP_ADD, 8'h20, 8'd0, 8'd0), mk(OP_ADD, 8'h21, 8'd0, 8'd0), 3'd0, 3'd0, 1'b0);
    tick();
    applyStimulus(2'b11, mk(OP_ADD, 8'h22, 8'd0, 8'd0), mk(OP_ADD, 8'h23, 8'd0, 8'd0), 3'd0, 3'd0, 1'b0);
    tick();
    applyStimulus(2'b01, mk(OP_ADD, 8'h24, 8'd0, 8'd0), 32'h0, 3'd0, 3'd0, 1'b0);
    tick();
    checkOutput("t6_occ5", 64'(occupancy), 64'd5);
    applyStimulus(2'b11, mk(OP_ADD, 8'h30, 8'd0, 8'd0), mk(OP_ADD, 8'h31, 8'd0, 8'd0), 3'd2, 3'd2, 1'b1);
    tick();
    checkOutput("t6_flush_occ", 64'(occupancy), 64'd0);
    checkOutput("t6_flush_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_flush_ready", 64'(in_ready), 64'd1);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd2, 3'd2, 1'b0);
    tick();
    checkOutput("t6_post_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_post_occ", 64'(occupancy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
